// File: rtl/regbank_reader.sv
// Burst reader: walks a register bank read port from first_addr for up to one full bank of words,
// presenting each captured word on a valid/ready output.
module regbank_reader #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [3:0]        count,
  output logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] rd,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  // Cap the burst at one pass over the bank so no register is emitted twice.
  localparam logic [3:0] MaxWords = (ADDR_W >= 4) ? 4'd15 : 4'(2 ** ADDR_W);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StHold,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [3:0]          rem_q, rem_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          ptr_d   = first_addr;
          rem_d   = (count > MaxWords) ? MaxWords : count;
          state_d = (count == 4'd0) ? StDone : StRead;
        end
      end
      StRead: begin
        data_d  = rd;
        addr_d  = ptr_q;
        valid_d = 1'b1;
        state_d = StHold;
      end
      StHold: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          rem_d   = rem_q - 4'd1;
          if (rem_q == 4'd1) begin
            state_d = StDone;
          end else begin
            ptr_d   = ptr_q + 1'b1;
            state_d = StRead;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  assign ra        = ptr_q;
  assign out_data  = data_q;
  assign out_addr  = addr_q;
  assign out_valid = valid_q;
  assign busy      = (state_q == StRead) || (state_q == StHold);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_regbank_reader.sv
// Randomized bench for regbank_reader: a queue of expected addresses per burst, derived from
// first_addr/count, is checked against each word offered on the output port.
module tb_regbank_reader;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] first_addr;
  logic [3:0]    count;
  logic [AW-1:0] ra;
  logic [DW-1:0] rd;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  logic [DW-1:0] bank [8];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign rd = bank[ra];

  regbank_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first_addr (first_addr),
    .count      (count),
    .ra         (ra),
    .rd         (rd),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_bank();
    for (int i = 0; i < 8; i++) bank[i] = 8'($urandom);
  endtask

  // Runs one burst from IDLE; all outputs are sampled 1 time unit after the edge.
  task automatic run_burst(input logic [2:0] fa, input logic [3:0] cnt, input int ready_pct,
                           input int stall_at, input bit poke_start);
    logic [2:0] exp_q[$];
    int n, cyc, got, stall_left;
    bit stalled, hs, last_hs, done_seen;
    n = (cnt > 8) ? 8 : int'(cnt);
    for (int i = 0; i < n; i++) exp_q.push_back(3'((int'(fa) + i) % 8));
    start = 1'b1; first_addr = fa; count = cnt; out_ready = 1'b0;
    tick();
    start = 1'b0; first_addr = 3'($urandom); count = 4'($urandom);
    if (n == 0) begin
      checks++;
      if ({done, out_valid, busy} !== 3'b100)
        $display("FAIL zero_count_n1: got done/valid/busy %b expected 100", {done, out_valid, busy});
      tick();
      checks++;
      if ({done, out_valid, busy} !== 3'b000)
        $display("FAIL zero_count_n2: got done/valid/busy %b expected 000", {done, out_valid, busy});
      if ({done, out_valid, busy} !== 3'b000) errors++;
      return;
    end
    checks++;
    if (ra !== fa) begin
      errors++; $display("FAIL first_ra: got %0d expected %0d", ra, fa);
    end
    checks++;
    if ({busy, out_valid, done} !== 3'b100) begin
      errors++; $display("FAIL n1_status: got busy/valid/done %b expected 100", {busy, out_valid, done});
    end
    cyc = 1; got = 0; stall_left = 0; stalled = 0; last_hs = 0; done_seen = 0;
    while (!done_seen && cyc < 300) begin
      hs = 0;
      if (cyc == 2) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++; $display("FAIL valid_latency: got %b expected 1", out_valid);
        end
      end
      if (ready_pct == 100 && stall_at < 0 && cyc <= 2 * n) begin
        checks++;
        if (out_valid !== 1'((cyc % 2) == 0)) begin
          errors++;
          $display("FAIL throughput: got valid %b expected %b at cycle %0d", out_valid,
                   1'((cyc % 2) == 0), cyc);
        end
      end
      if (done === 1'b1) begin
        done_seen = 1;
        checks++;
        if (!last_hs || exp_q.size() != 0) begin
          errors++;
          $display("FAIL done_timing: got last_hs %0d left %0d expected 1 0", last_hs, exp_q.size());
        end
        checks++;
        if ({out_valid, busy} !== 2'b00) begin
          errors++; $display("FAIL done_status: got valid/busy %b expected 00", {out_valid, busy});
        end
        if (ready_pct == 100 && stall_at < 0) begin
          checks++;
          if (cyc != 2 * n + 1) begin
            errors++; $display("FAIL done_cycle: got %0d expected %0d", cyc, 2 * n + 1);
          end
        end
      end else if (out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL extra_word: got addr %0d expected none", out_addr);
        end else begin
          if (out_addr !== exp_q[0] || ra !== exp_q[0]) begin
            errors++;
            $display("FAIL word_addr: got out_addr %0d ra %0d expected %0d", out_addr, ra, exp_q[0]);
          end
          checks++;
          if (out_data !== bank[exp_q[0]]) begin
            errors++; $display("FAIL word_data: got %02h expected %02h", out_data, bank[exp_q[0]]);
          end
          checks++;
          if (busy !== 1'b1) begin
            errors++; $display("FAIL hold_busy: got %b expected 1", busy);
          end
        end
        if (got == stall_at && !stalled) begin
          stalled = 1; stall_left = 5;
        end
      end
      if (!done_seen) begin
        if (stall_left > 0) begin
          out_ready = 1'b0; stall_left--;
        end else begin
          out_ready = ($urandom_range(99) < ready_pct);
        end
        if (out_valid === 1'b1 && out_ready && exp_q.size() > 0) begin
          void'(exp_q.pop_front()); got++; hs = 1;
        end
        start = poke_start && ($urandom_range(1) == 1);
        first_addr = 3'($urandom); count = 4'($urandom);
        tick();
        cyc++;
        last_hs = hs;
      end
    end
    checks++;
    if (!done_seen) begin
      errors++; $display("FAIL burst_timeout: got no done expected done after %0d words", n);
      return;
    end
    start = 1'b0; out_ready = 1'($urandom);
    tick();
    checks++;
    if ({done, busy, out_valid} !== 3'b000 || got != n) begin
      errors++;
      $display("FAIL after_done: got done/busy/valid %b words %0d expected 000 %0d",
               {done, busy, out_valid}, got, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; first_addr = '0; count = '0;
    tick(); tick();
    checks++;
    if ({ra, out_data, out_addr, out_valid, busy, done} !== 17'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %05h expected 00000", {ra, out_data, out_addr, out_valid, busy, done});
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      first_addr = 3'($urandom); count = 4'($urandom); out_ready = 1'($urandom);
      tick();
      checks++;
      if ({ra, out_data, out_addr, out_valid, busy, done} !== 17'h0) begin
        errors++;
        $display("FAIL idle_outputs: got %05h expected 00000", {ra, out_data, out_addr, out_valid, busy, done});
      end
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 8; i++) bank[i] = 8'(16 * i);
    run_burst(3'd0, 4'd8, 100, -1, 1'b0);
  endtask

  task automatic test_wrap();
    randomize_bank();
    run_burst(3'd6, 4'd4, 100, -1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      randomize_bank();
      run_burst(3'($urandom), 4'($urandom_range(8, 1)), 60, -1, 1'b0);
    end
  endtask

  task automatic test_stall();
    randomize_bank();
    run_burst(3'($urandom), 4'd8, 100, 2, 1'b0);
    run_burst(3'($urandom), 4'd5, 70, 0, 1'b0);
  endtask

  task automatic test_count_edges();
    randomize_bank();
    run_burst(3'($urandom), 4'd0, 100, -1, 1'b0);
    run_burst(3'($urandom), 4'd12, 100, -1, 1'b1);
    run_burst(3'($urandom), 4'd15, 70, -1, 1'b1);
    run_burst(3'($urandom), 4'd9, 50, -1, 1'b1);
    run_burst(3'($urandom), 4'd1, 100, -1, 1'b1);
  endtask

  task automatic test_abort();
    int words;
    randomize_bank();
    start = 1'b1; first_addr = 3'($urandom); count = 4'd8; out_ready = 1'b0;
    tick();
    start = 1'b0;
    words = 0;
    for (int c = 0; c < 50; c++) begin
      if (out_valid === 1'b1 && words == 2) break;
      out_ready = 1'b1;
      if (out_valid === 1'b1) words++;
      tick();
    end
    checks++;
    if (out_valid !== 1'b1 || words != 2) begin
      errors++; $display("FAIL abort_reach_hold: got valid %b words %0d expected 1 2", out_valid, words);
    end
    rst = 1'b1; start = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    checks++;
    if ({ra, out_data, out_addr, out_valid, busy, done} !== 17'h0) begin
      errors++;
      $display("FAIL abort_outputs: got %05h expected 00000", {ra, out_data, out_addr, out_valid, busy, done});
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if ({out_valid, busy, done} !== 3'b000) begin
        errors++; $display("FAIL abort_quiet: got valid/busy/done %b expected 000", {out_valid, busy, done});
      end
    end
    run_burst(3'($urandom), 4'd8, 100, -1, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) bank[i] = '0;
    test_reset();
    test_sequential();
    test_wrap();
    test_stall();
    test_count_edges();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
